// File: rtl/centroid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : centroid_pkg
// Description : Shared types and constants for the centroid tracker: the
//               tracker FSM state encoding, default widths and the fixed
//               tabulate-to-result latency.
// Revision    : 1.0 - initial release
// ============================================================================
package centroid_pkg;

  localparam int DEF_H_WIDTH   = 11;
  localparam int DEF_V_WIDTH   = 10;
  localparam int DEF_CNT_WIDTH = 20;
  localparam int DEF_SUM_WIDTH = 32;

  // One cycle to load the dividers, SUM_WIDTH iterations, one cycle in DONE.
  localparam int DIV_LATENCY = DEF_SUM_WIDTH + 2;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage : centroid_pkg
`default_nettype wire

// File: rtl/centroid_tracker_iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : iter_divider
// Description : Unsigned restoring divider, one quotient bit per cycle.
//               start_in loads the operands; WIDTH cycles later done_out
//               pulses for one cycle with quotient/remainder valid.
// Ports       : clk_in, rst_in (async, active-high)
//               start_in              - load operands and begin
//               dividend_in/divisor_in - operands (divisor must be nonzero)
//               quotient_out/remainder_out - results, valid from done_out
//               busy_out              - iterations in progress
//               done_out              - single-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  // r_quot doubles as the dividend shift register: its MSB is shifted into
  // the partial remainder while the new quotient bit enters at the LSB.
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_trial = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_trial >= {1'b0, r_div});
  // The difference is below the divisor whenever it is used, so the low
  // WIDTH bits are exact.
  assign w_diff  = w_trial[WIDTH-1:0] - r_div;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start_in) begin
        r_quot <= dividend_in;
        r_rem  <= '0;
        r_div  <= divisor_in;
        r_cnt  <= CW'(WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_ge ? w_diff : w_trial[WIDTH-1:0];
        r_quot <= {r_quot[WIDTH-2:0], w_ge};
        r_cnt  <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign quotient_out  = r_quot;
  assign remainder_out = r_rem;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

endmodule : iter_divider
`default_nettype wire

// File: rtl/centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module      : centroid_tracker
// Description : Accumulates x/y of masked pixels over a frame; on the
//               frame-end strobe divides both sums by the pixel count and
//               emits one floor-rounded centroid with a single-cycle valid.
// Ports       : clk_in, rst_in (async, active-high)
//               hcount_in/vcount_in - pixel coordinates
//               valid_in, mask_in   - pixel qualifier / target membership
//               tabulate_in         - frame-end strobe
//               x_out/y_out         - centroid, held between updates
//               valid_out           - one-cycle update pulse
//               busy_out            - high while dividing
// Revision    : 1.0 - initial release
// ============================================================================
module centroid_tracker
  import centroid_pkg::*;
#(
  parameter int H_WIDTH   = DEF_H_WIDTH,
  parameter int V_WIDTH   = DEF_V_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic               valid_in,
  input  logic               mask_in,
  input  logic               tabulate_in,
  output logic [H_WIDTH-1:0] x_out,
  output logic [V_WIDTH-1:0] y_out,
  output logic               valid_out,
  output logic               busy_out
);

  state_t r_state;
  state_t w_state_nxt;

  logic [SUM_WIDTH-1:0] r_sum_x;
  logic [SUM_WIDTH-1:0] r_sum_y;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [H_WIDTH-1:0]   r_x;
  logic [V_WIDTH-1:0]   r_y;
  logic                 r_valid;

  logic                 w_pix;
  logic [SUM_WIDTH-1:0] w_sum_x_nxt;
  logic [SUM_WIDTH-1:0] w_sum_y_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_accept;
  logic                 w_div_done;

  logic [SUM_WIDTH-1:0] w_quot_x;
  logic [SUM_WIDTH-1:0] w_quot_y;
  logic [SUM_WIDTH-1:0] w_rem_x;
  logic [SUM_WIDTH-1:0] w_rem_y;
  logic                 w_busy_x;
  logic                 w_busy_y;
  logic                 w_done_x;
  logic                 w_done_y;
  logic                 w_unused;

  // A saturated count drops the pixel entirely, which keeps the sums
  // bounded by (2^CNT_WIDTH - 1) * max coordinate.
  assign w_pix       = valid_in & mask_in & ~(&r_cnt);
  assign w_sum_x_nxt = r_sum_x + (w_pix ? SUM_WIDTH'(hcount_in) : '0);
  assign w_sum_y_nxt = r_sum_y + (w_pix ? SUM_WIDTH'(vcount_in) : '0);
  assign w_cnt_nxt   = r_cnt + CNT_WIDTH'(w_pix);

  // The count test includes a same-cycle pixel so it closes with its frame.
  assign w_accept    = (r_state == ACCUM) & tabulate_in & (w_cnt_nxt != '0);
  assign w_div_done  = w_done_x & w_done_y;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else begin
      r_sum_x <= w_sum_x_nxt;
      r_sum_y <= w_sum_y_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  iter_divider #(.WIDTH(SUM_WIDTH)) u_div_x (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (w_accept),
    .dividend_in  (w_sum_x_nxt),
    .divisor_in   (SUM_WIDTH'(w_cnt_nxt)),
    .quotient_out (w_quot_x),
    .remainder_out(w_rem_x),
    .busy_out     (w_busy_x),
    .done_out     (w_done_x)
  );

  iter_divider #(.WIDTH(SUM_WIDTH)) u_div_y (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (w_accept),
    .dividend_in  (w_sum_y_nxt),
    .divisor_in   (SUM_WIDTH'(w_cnt_nxt)),
    .quotient_out (w_quot_y),
    .remainder_out(w_rem_y),
    .busy_out     (w_busy_y),
    .done_out     (w_done_y)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_accept) w_state_nxt = DIVIDE;
      DIVIDE:  if (w_div_done) w_state_nxt = DONE;
      DONE:    w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Results are captured on the DIVIDE->DONE edge so that x/y and the
  // valid pulse are all presented during the DONE cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if ((r_state == DIVIDE) && w_div_done) begin
        r_x     <= w_quot_x[H_WIDTH-1:0];
        r_y     <= w_quot_y[V_WIDTH-1:0];
        r_valid <= 1'b1;
      end
    end
  end

  // Upper quotient bits are zero because a mean never exceeds the largest
  // coordinate; remainders and per-divider busy flags are not needed here.
  assign w_unused = ^{w_quot_x[SUM_WIDTH-1:H_WIDTH], w_quot_y[SUM_WIDTH-1:V_WIDTH],
                      w_rem_x, w_rem_y, w_busy_x, w_busy_y};

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign valid_out = r_valid;
  assign busy_out  = (r_state == DIVIDE);

endmodule : centroid_tracker
`default_nettype wire

// File: tb/tb_centroid_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_centroid_tracker
// Description : Self-checking bench for centroid_tracker. Frame vectors come
//               from a table plus hand-written multi-cycle sequences; each
//               accepted frame pushes its expected centroid and due cycle to
//               a queue that a monitor pops on every valid_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_centroid_tracker;

  localparam int HW  = 11;
  localparam int VW  = 10;
  localparam int CW  = 20;
  localparam int SW  = 32;
  localparam int LAT = SW + 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [HW-1:0] hcount_in;
  logic [VW-1:0] vcount_in;
  logic          valid_in;
  logic          mask_in;
  logic          tabulate_in;
  logic [HW-1:0] x_out;
  logic [VW-1:0] y_out;
  logic          valid_out;
  logic          busy_out;

  centroid_tracker #(
    .H_WIDTH  (HW),
    .V_WIDTH  (VW),
    .CNT_WIDTH(CW),
    .SUM_WIDTH(SW)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .valid_in   (valid_in),
    .mask_in    (mask_in),
    .tabulate_in(tabulate_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .valid_out  (valid_out),
    .busy_out   (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_in) cyc = cyc + 1;

  typedef struct {
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    int            due;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;

  typedef struct {
    int                 n;
    logic [3:0][HW-1:0] px;
    logic [3:0][VW-1:0] py;
    logic [3:0]         pm;
    bit                 tab_with_last;
    logic [HW-1:0]      ex;
    logic [VW-1:0]      ey;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Outputs are sampled half a cycle away from the active edge.
  always @(negedge clk_in) begin
    if (!rst_in && valid_out) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got x=%0d y=%0d with no result pending (cycle %0d)",
                 x_out, y_out, cyc);
      end else begin
        e_mon = q.pop_front();
        check("result_x", x_out, e_mon.x);
        check("result_y", y_out, e_mon.y);
        check("latency_cycle", cyc, e_mon.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [HW-1:0] x, input logic [VW-1:0] y,
                       input logic v, input logic m, input logic t);
    hcount_in   = x;
    vcount_in   = y;
    valid_in    = v;
    mask_in     = m;
    tabulate_in = t;
    tick();
    valid_in    = 1'b0;
    mask_in     = 1'b0;
    tabulate_in = 1'b0;
  endtask

  task automatic expect_result(input logic [HW-1:0] x, input logic [VW-1:0] y);
    exp_t e;
    e.x   = x;
    e.y   = y;
    e.due = cyc + LAT;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < LAT + 20 && q.size() != 0; i++) tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d results pending expected 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    // Frame vectors: pixels (x, y, mask), tabulate placement, floor centroid.
    vecs[0].n = 1; vecs[0].tab_with_last = 0;
    vecs[0].px[0] = 100; vecs[0].py[0] = 50; vecs[0].pm[0] = 1;
    vecs[0].ex = 100; vecs[0].ey = 50;

    vecs[1].n = 4; vecs[1].tab_with_last = 0;
    vecs[1].px[0] = 10;   vecs[1].py[0] = 20;  vecs[1].pm[0] = 1;
    vecs[1].px[1] = 20;   vecs[1].py[1] = 40;  vecs[1].pm[1] = 1;
    vecs[1].px[2] = 1000; vecs[1].py[2] = 700; vecs[1].pm[2] = 0;
    vecs[1].px[3] = 31;   vecs[1].py[3] = 61;  vecs[1].pm[3] = 1;
    vecs[1].ex = 20; vecs[1].ey = 40;

    vecs[2].n = 3; vecs[2].tab_with_last = 0;
    vecs[2].px[0] = 2047; vecs[2].py[0] = 1023; vecs[2].pm[0] = 1;
    vecs[2].px[1] = 2047; vecs[2].py[1] = 1023; vecs[2].pm[1] = 1;
    vecs[2].px[2] = 0;    vecs[2].py[2] = 0;    vecs[2].pm[2] = 1;
    vecs[2].ex = 1364; vecs[2].ey = 682;

    vecs[3].n = 2; vecs[3].tab_with_last = 1;
    vecs[3].px[0] = 4; vecs[3].py[0] = 4; vecs[3].pm[0] = 1;
    vecs[3].px[1] = 8; vecs[3].py[1] = 8; vecs[3].pm[1] = 1;
    vecs[3].ex = 6; vecs[3].ey = 6;

    rst_in = 1'b1; hcount_in = '0; vcount_in = '0;
    valid_in = 1'b0; mask_in = 1'b0; tabulate_in = 1'b0;
    repeat (3) tick();
    check("reset_x", x_out, 0);
    check("reset_y", y_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_busy", busy_out, 0);
    rst_in = 1'b0;
    tick();

    // Empty frame: tabulate must be ignored.
    drive(0, 0, 1'b1, 1'b0, 1'b1);
    check("empty_busy", busy_out, 0);
    repeat (50) tick();
    check("empty_x_hold", x_out, 0);
    check("empty_y_hold", y_out, 0);

    for (int v = 0; v < 4; v++) begin
      for (int p = 0; p < vecs[v].n; p++) begin
        if (vecs[v].tab_with_last && p == vecs[v].n - 1) begin
          expect_result(vecs[v].ex, vecs[v].ey);
          drive(vecs[v].px[p], vecs[v].py[p], 1'b1, vecs[v].pm[p], 1'b1);
        end else begin
          drive(vecs[v].px[p], vecs[v].py[p], 1'b1, vecs[v].pm[p], 1'b0);
        end
      end
      if (!vecs[v].tab_with_last) begin
        expect_result(vecs[v].ex, vecs[v].ey);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
      end
      drain("vector");
      check("hold_x_after_vec", x_out, vecs[v].ex);
    end

    // Dropped tabulate during DIVIDE; the injected pixel starts the next frame.
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    expect_result(1, 1);
    drive(2, 2, 1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    check("busy_in_divide", busy_out, 1);
    drive(500, 300, 1'b1, 1'b1, 1'b1);
    drain("drop_tab_first");
    check("busy_after_done", busy_out, 0);
    expect_result(500, 300);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    drain("drop_tab_second");

    // Random frames against a floor-division model.
    for (int f = 0; f < 3; f++) begin
      int n;
      longint sx, sy, c;
      logic [HW-1:0] rx;
      logic [VW-1:0] ry;
      logic rm;
      n = $urandom_range(1, 6);
      sx = 0; sy = 0; c = 0;
      for (int p = 0; p < n; p++) begin
        rx = HW'($urandom_range(0, 2047));
        ry = VW'($urandom_range(0, 1023));
        rm = (p == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (rm) begin
          sx += rx; sy += ry; c++;
        end
        if (p == n - 1) begin
          expect_result(HW'(sx / c), VW'(sy / c));
          drive(rx, ry, 1'b1, rm, 1'b1);
        end else begin
          drive(rx, ry, 1'b1, rm, 1'b0);
        end
      end
      drain("random");
    end

    // Reset in the middle of a divide aborts the frame.
    expect_result(6, 6);
    drive(6, 6, 1'b1, 1'b1, 1'b1);
    drain("pre_reset");
    drive(3, 3, 1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    check("busy_before_reset", busy_out, 1);
    rst_in = 1'b1;
    #1;
    check("abort_x", x_out, 0);
    check("abort_y", y_out, 0);
    check("abort_busy", busy_out, 0);
    check("abort_valid", valid_out, 0);
    tick();
    tick();
    rst_in = 1'b0;
    repeat (50) tick();
    check("post_abort_x", x_out, 0);
    expect_result(7, 9);
    drive(7, 9, 1'b1, 1'b1, 1'b1);
    drain("after_reset");

    repeat (50) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_centroid_tracker
`default_nettype wire
